// File: rtl/seven_seg_pkg.sv
// -----------------------------------------------------------------------------
// seven_seg_pkg
// Shared constants for the seven-segment display controller.
// Contents:
//   - Avalon register word addresses (CTRL, BLINK_MASK, DUTY)
//   - CTRL register bit indices
//   - Hex-to-segment table and lookup function; segments are active-high and
//     the bit order is gfedcba (bit 0 = segment a)
// -----------------------------------------------------------------------------
package seven_seg_pkg;

    localparam logic [3:0] ADDR_CTRL       = 4'd8;
    localparam logic [3:0] ADDR_BLINK_MASK = 4'd9;
    localparam logic [3:0] ADDR_DUTY       = 4'd10;

    localparam int unsigned CTRL_DECODE   = 0;
    localparam int unsigned CTRL_BLANK    = 1;
    localparam int unsigned CTRL_BLINK_EN = 2;
    localparam int unsigned CTRL_W        = 3;

    // Entry 15 is listed first (packed array, MSB first).
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] i_nibble);
        return HEX_SEG_TABLE[i_nibble];
    endfunction

endpackage

// File: rtl/seven_seg_blink_timer.sv
// -----------------------------------------------------------------------------
// seven_seg_blink_timer
// Blink phase generator. The counter runs 0..BLINK_DIV-1 while i_run is high.
// When the counter wraps, o_phase toggles. While i_run is low, the counter and
// the phase are held at 0, so a fresh start always begins at count 0 with
// phase 0.
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   i_run    in   count enable; low clears counter and phase
//   o_phase  out  blink phase (1 = masked digits dark)
// -----------------------------------------------------------------------------
module seven_seg_blink_timer #(
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_run,
    output logic o_phase
);

    localparam int unsigned      CNT_W   = $clog2(BLINK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_d;
    logic             r_phase;
    logic             w_phase_d;

    always_comb begin
        w_cnt_d   = r_cnt;
        w_phase_d = r_phase;
        if (!i_run) begin
            w_cnt_d   = '0;
            w_phase_d = 1'b0;
        end else if (r_cnt == CNT_MAX) begin
            w_cnt_d   = '0;
            w_phase_d = ~r_phase;
        end else begin
            w_cnt_d = r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_d;
            r_phase <= w_phase_d;
        end
    end

    assign o_phase = r_phase;

endmodule

// File: rtl/seven_seg_ctrl.sv
// -----------------------------------------------------------------------------
// seven_seg_ctrl
// Multi-digit seven-segment controller with an Avalon-MM slave interface.
// Each digit has its own register. The controller supports optional hex
// decode, global blanking, per-digit blink and selectable output polarity.
// Optional feature: define SEVEN_SEG_PWM_EN to add the DUTY register (addr 10)
// and a 16-step brightness gate. Without that macro, the digits run at full
// brightness.
// Ports:
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   address     in   word address (4 bits)
//   chipselect  in   slave select
//   write_n     in   active-low write strobe
//   writedata   in   write data (32 bits)
//   readdata    out  read data, combinational, zero wait states
//   out_port    out  segment pins, digit i on [7i+6:7i], gfedcba order
// -----------------------------------------------------------------------------
module seven_seg_ctrl
    import seven_seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned BLINK_DIV  = 25000000,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [3:0]              address,
    input  logic                    chipselect,
    input  logic                    write_n,
    input  logic [31:0]             writedata,
    output logic [31:0]             readdata,
    output logic [7*NUM_DIGITS-1:0] out_port
);

    localparam logic [7*NUM_DIGITS-1:0] OUT_DARK = {(7*NUM_DIGITS){ACTIVE_LOW}};

    logic [6:0]              r_digit [NUM_DIGITS];
    logic [CTRL_W-1:0]       r_ctrl;
    logic [CTRL_W-1:0]       w_ctrl_d;
    logic [NUM_DIGITS-1:0]   r_mask;
    logic [7*NUM_DIGITS-1:0] r_out;
    logic [7*NUM_DIGITS-1:0] w_out_d;
    logic [6:0]              w_seg;
    logic                    w_wr_en;
    logic                    w_blink_run;
    logic                    w_phase;
    logic                    w_lit;
    logic                    w_unused;

    assign w_wr_en  = chipselect && !write_n;
    assign w_unused = ^writedata[31:7];

    always_comb begin
        w_ctrl_d = r_ctrl;
        if (w_wr_en && (address == ADDR_CTRL)) begin
            w_ctrl_d = writedata[CTRL_W-1:0];
        end
    end

    // The timer runs only when BLINK_EN is set both now and after this edge.
    // A 0->1 write therefore starts at count 0 on the following edge. A
    // clearing write forces phase to 0 even on a wrap edge.
    assign w_blink_run = r_ctrl[CTRL_BLINK_EN] & w_ctrl_d[CTRL_BLINK_EN];

    seven_seg_blink_timer #(
        .BLINK_DIV (BLINK_DIV)
    ) u_blink_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .i_run   (w_blink_run),
        .o_phase (w_phase)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_digit[i] <= '0;
            end
            r_ctrl <= '0;
            r_mask <= '0;
        end else begin
            r_ctrl <= w_ctrl_d;
            if (w_wr_en) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (address == 4'(i)) begin
                        r_digit[i] <= writedata[6:0];
                    end
                end
                if (address == ADDR_BLINK_MASK) begin
                    r_mask <= writedata[NUM_DIGITS-1:0];
                end
            end
        end
    end

`ifdef SEVEN_SEG_PWM_EN
    logic [3:0] r_duty;
    logic [3:0] r_pwm_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_duty    <= 4'hF;
            r_pwm_cnt <= 4'h0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 4'd1;
            if (w_wr_en && (address == ADDR_DUTY)) begin
                r_duty <= writedata[3:0];
            end
        end
    end

    assign w_lit = (r_pwm_cnt <= r_duty);
`else
    assign w_lit = 1'b1;
`endif

    always_comb begin
        w_out_d = '0;
        w_seg   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_ctrl[CTRL_DECODE]) begin
                w_seg = hex_to_seg(r_digit[i][3:0]);
            end else begin
                w_seg = r_digit[i];
            end
            if (r_ctrl[CTRL_BLANK] || !w_lit ||
                (r_ctrl[CTRL_BLINK_EN] && r_mask[i] && w_phase)) begin
                w_seg = '0;
            end
            w_out_d[7*i +: 7] = ACTIVE_LOW ? ~w_seg : w_seg;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out <= OUT_DARK;
        end else begin
            r_out <= w_out_d;
        end
    end

    assign out_port = r_out;

    always_comb begin
        readdata = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (address == 4'(i)) begin
                readdata[6:0] = r_digit[i];
            end
        end
        if (address == ADDR_CTRL) begin
            readdata[CTRL_W-1:0] = r_ctrl;
        end
        if (address == ADDR_BLINK_MASK) begin
            readdata[NUM_DIGITS-1:0] = r_mask;
        end
`ifdef SEVEN_SEG_PWM_EN
        if (address == ADDR_DUTY) begin
            readdata[3:0] = r_duty;
        end
`endif
    end

endmodule

// File: doc/seven_seg_ctrl.md
Name: seven_seg_ctrl

Overview:
Multi-digit seven-segment display controller with an Avalon-MM slave interface, replacing the single-digit raw PIO. It holds one register per digit with optional hex decode, global blanking, per-digit blink driven by an internal timer, and active-low/active-high output polarity. It sits on the Nios system interconnect and drives the board HEX displays directly.

Parameters:
- NUM_DIGITS, 6, number of displays driven (1..8).
- BLINK_DIV, 25000000, clk cycles per blink half-period; must be ≥2.
- ACTIVE_LOW, 1, 1 = segment lit when pin is 0 (DE-series HEX); 0 = lit when 1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  4  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, combinational, 0 wait states, 0 read latency.
- out_port  out  7*NUM_DIGITS  segment pins; digit i on [7i+6:7i], bit order gfedcba (bit 0 = a).

Behaviour:
- Reset is asynchronous, active-low; clock is clk.
- Write occurs when chipselect && !write_n. Reads have no side effects.
- Register map:
  - addr 0..NUM_DIGITS-1: DIGIT[i][6:0], reset 0.
  - addr 8: CTRL[2:0], reset 0. Bit0 DECODE, bit1 BLANK, bit2 BLINK_EN.
  - addr 9: BLINK_MASK[NUM_DIGITS-1:0], reset 0.
  - addr 10: DUTY[3:0], reset 15 (optional feature only).
  - Writes to any other address are ignored; reads from any other address return 0. Unused readdata bits are 0.
- Segment value per digit (active-high, before polarity):
  - DECODE=1: hex table applied to DIGIT[i][3:0]. 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F, A=0x77, b=0x7C, C=0x39, d=0x5E, E=0x79, F=0x71.
  - DECODE=0: DIGIT[i][6:0] raw.
- Digit forced dark when any of:
  - BLANK=1.
  - BLINK_EN=1 && BLINK_MASK[i]=1 && phase=1.
  - The optional PWM gate is off.
- Polarity: when ACTIVE_LOW=1, out_port is the inverse of the active-high value. Dark means all-1 pins when ACTIVE_LOW=1, all-0 when ACTIVE_LOW=0. Reset value of out_port is the dark value.
- Latency: register written at edge N; out_port is registered and reflects the new value at edge N+1.
- Blink timer:
  - Counter runs 0..BLINK_DIV-1; on reaching BLINK_DIV-1 it wraps to 0 and phase toggles.
  - Counter and phase reset to 0.
  - While BLINK_EN=0, counter and phase are held at 0.
  - A CTRL write that sets BLINK_EN from 0→1 starts counting from 0 with phase 0, so the masked digit is lit for the first BLINK_DIV cycles.
- Simultaneous events: register writes take effect regardless of blink wrap on the same edge. A CTRL write clearing BLINK_EN on a wrap edge leaves phase at 0.
- Reset mid-operation: all registers, counters and out_port return to reset values immediately.

Optional Feature:
- Macro: SEVEN_SEG_PWM_EN.
- Defined:
  - DUTY register at addr 10 (read/write, reset 15).
  - 4-bit free-running counter pwm_cnt, reset 0.
  - Digits are lit only when pwm_cnt <= DUTY: 15 = always lit, 0 = lit 1 cycle in 16.
  - The gate applies to all digits and is registered with out_port.
- Not defined: no DUTY register (addr 10 reads 0, writes ignored), no PWM counter, always full brightness.

Decomposition:
- Package seven_seg_pkg:
  - Register address constants: ADDR_CTRL=8, ADDR_BLINK_MASK=9, ADDR_DUTY=10.
  - CTRL bit indices.
  - 16-entry hex-to-segment constant table.
  - Function hex_to_seg(4-bit) → 7-bit.
- One sub-module: seven_seg_blink_timer (counter, phase, enable/restart input, phase output). Everything else stays in seven_seg_ctrl.

Test Plan:
1. Reset, ACTIVE_LOW=1 → out_port all 1s; readdata of addr 0, 8, 9 = 0.
2. Write CTRL=1, DIGIT0=0xA, DIGIT1=0x1 → digit0 pins 0x08, digit1 pins 0x79 one edge after each write; readback of DIGIT0 = 0x0000000A.
3. Write CTRL=0, DIGIT2=0x55 → digit2 pins 0x2A; then write CTRL=2 → every digit 0x7F on the next edge.
4. BLINK_DIV=4 in the bench: BLINK_MASK=0x1, CTRL=5, DIGIT0=0 → digit0 alternates 0x40 for 4 cycles / 0x7F for 4 cycles; digit1 steady 0x40.
5. Write to addr 12 with data 0xFFFFFFFF → no register changes; read addr 12 → 0. Assert reset_n mid-blink → out_port dark and phase 0 without waiting for a clock edge.
6. With SEVEN_SEG_PWM_EN, DUTY=3, CTRL=1, DIGIT0=8 → digit0 lit (0x00) exactly 4 of every 16 cycles; without the macro, addr 10 reads 0 and digit0 is steadily lit.
